arf_rename_multi: RTL and testbench

Parametrised architectural register file with integrated rename table for the DP stage, generalising the single-issue ARF to DISP_WIDTH dispatch slots and COMMIT_WIDTH commit slots. It provides committed data, busy bits and RRF tags to each dispatch slot's two source operands, with intra-group dependency forwarding and commit-data bypass. It also provides a one-cycle flush that drops all speculative renames on misprediction recovery.

---
 rtl/arf_rename_multi.sv | 116 +++++++++++
 tb/tb_arf_rename_multi.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arf_rename_multi.sv
// Multi-slot architectural register file with rename table (data/busy/tag per register).
// Reads bypass same-cycle commits and forward renames from older slots in the dispatch group.
module arf_rename_multi #(
    parameter int REG_NUM      = 32,
    parameter int REG_SEL      = 5,
    parameter int DATA_LEN     = 32,
    parameter int RRF_SEL      = 6,
    parameter int DISP_WIDTH   = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [DISP_WIDTH*REG_SEL-1:0]    rs1_i,
    input  logic [DISP_WIDTH*REG_SEL-1:0]    rs2_i,
    output logic [DISP_WIDTH*DATA_LEN-1:0]   rs1_arf_data_o,
    output logic [DISP_WIDTH*DATA_LEN-1:0]   rs2_arf_data_o,
    output logic [DISP_WIDTH-1:0]            rs1_arf_busy_o,
    output logic [DISP_WIDTH-1:0]            rs2_arf_busy_o,
    output logic [DISP_WIDTH*RRF_SEL-1:0]    rs1_arf_rrftag_o,
    output logic [DISP_WIDTH*RRF_SEL-1:0]    rs2_arf_rrftag_o,
    input  logic [DISP_WIDTH-1:0]            dst_en_setbusy_i,
    input  logic [DISP_WIDTH*REG_SEL-1:0]    dst_num_setbusy_i,
    input  logic [DISP_WIDTH*RRF_SEL-1:0]    dst_rrftag_setbusy_i,
    input  logic [COMMIT_WIDTH-1:0]          completed_we_i,
    input  logic [COMMIT_WIDTH*REG_SEL-1:0]  completed_dst_num_i,
    input  logic [COMMIT_WIDTH*RRF_SEL-1:0]  completed_dst_rrftag_i,
    input  logic [COMMIT_WIDTH*DATA_LEN-1:0] from_rrfdata_i,
    input  logic                             flush_i
);

    typedef struct packed {
        logic [DATA_LEN-1:0] data;
        logic                busy;
        logic [RRF_SEL-1:0]  tag;
    } read_t;

    logic [DATA_LEN-1:0] r_data [REG_NUM];
    logic                r_busy [REG_NUM];
    logic [RRF_SEL-1:0]  r_tag  [REG_NUM];

    // Loops run oldest to youngest so the youngest match is the one left standing.
    function automatic read_t readOperand(input logic [REG_SEL-1:0] rs, input int slot);
        read_t res;
        res.data = r_data[rs];
        res.busy = r_busy[rs];
        res.tag  = r_tag[rs];
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (completed_we_i[c] && (rs != '0) &&
                (completed_dst_num_i[c*REG_SEL +: REG_SEL] == rs)) begin
                res.data = from_rrfdata_i[c*DATA_LEN +: DATA_LEN];
                if (completed_dst_rrftag_i[c*RRF_SEL +: RRF_SEL] == r_tag[rs]) begin
                    res.busy = 1'b0;
                end
            end
        end
        for (int j = 0; j < DISP_WIDTH; j++) begin
            if ((j < slot) && dst_en_setbusy_i[j] && (rs != '0) &&
                (dst_num_setbusy_i[j*REG_SEL +: REG_SEL] == rs)) begin
                res.busy = 1'b1;
                res.tag  = dst_rrftag_setbusy_i[j*RRF_SEL +: RRF_SEL];
            end
        end
        return res;
    endfunction

    for (genvar k = 0; k < DISP_WIDTH; k++) begin : g_read
        read_t w_rd1;
        read_t w_rd2;

        assign w_rd1 = readOperand(rs1_i[k*REG_SEL +: REG_SEL], k);
        assign w_rd2 = readOperand(rs2_i[k*REG_SEL +: REG_SEL], k);

        assign rs1_arf_data_o[k*DATA_LEN +: DATA_LEN]  = w_rd1.data;
        assign rs1_arf_busy_o[k]                       = w_rd1.busy;
        assign rs1_arf_rrftag_o[k*RRF_SEL +: RRF_SEL]  = w_rd1.tag;
        assign rs2_arf_data_o[k*DATA_LEN +: DATA_LEN]  = w_rd2.data;
        assign rs2_arf_busy_o[k]                       = w_rd2.busy;
        assign rs2_arf_rrftag_o[k*RRF_SEL +: RRF_SEL]  = w_rd2.tag;
    end

    // Later nonblocking writes win: commit clear < flush clear / dispatch set.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < REG_NUM; r++) begin
                r_data[r] <= '0;
                r_busy[r] <= 1'b0;
                r_tag[r]  <= '0;
            end
        end else begin
            for (int c = 0; c < COMMIT_WIDTH; c++) begin
                if (completed_we_i[c] && (completed_dst_num_i[c*REG_SEL +: REG_SEL] != '0)) begin
                    r_data[completed_dst_num_i[c*REG_SEL +: REG_SEL]] <=
                        from_rrfdata_i[c*DATA_LEN +: DATA_LEN];
                    if (completed_dst_rrftag_i[c*RRF_SEL +: RRF_SEL] ==
                        r_tag[completed_dst_num_i[c*REG_SEL +: REG_SEL]]) begin
                        r_busy[completed_dst_num_i[c*REG_SEL +: REG_SEL]] <= 1'b0;
                    end
                end
            end
            if (flush_i) begin
                for (int r = 0; r < REG_NUM; r++) begin
                    r_busy[r] <= 1'b0;
                end
            end else begin
                for (int k = 0; k < DISP_WIDTH; k++) begin
                    if (dst_en_setbusy_i[k] && (dst_num_setbusy_i[k*REG_SEL +: REG_SEL] != '0)) begin
                        r_busy[dst_num_setbusy_i[k*REG_SEL +: REG_SEL]] <= 1'b1;
                        r_tag[dst_num_setbusy_i[k*REG_SEL +: REG_SEL]]  <=
                            dst_rrftag_setbusy_i[k*RRF_SEL +: RRF_SEL];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_arf_rename_multi.sv
// Directed, table-driven bench for arf_rename_multi (two dispatch slots, two commit slots).
// Each table row is one cycle: inputs are driven, reads checked, then the clock edge commits them.
module tb_arf_rename_multi;

    logic        clk;
    logic        reset_i;
    logic [9:0]  rs1_i, rs2_i;
    logic [63:0] rs1_arf_data_o, rs2_arf_data_o;
    logic [1:0]  rs1_arf_busy_o, rs2_arf_busy_o;
    logic [11:0] rs1_arf_rrftag_o, rs2_arf_rrftag_o;
    logic [1:0]  dst_en_setbusy_i;
    logic [9:0]  dst_num_setbusy_i;
    logic [11:0] dst_rrftag_setbusy_i;
    logic [1:0]  completed_we_i;
    logic [9:0]  completed_dst_num_i;
    logic [11:0] completed_dst_rrftag_i;
    logic [63:0] from_rrfdata_i;
    logic        flush_i;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct packed {
        logic [9:0]  rs1;
        logic [9:0]  rs2;
        logic [1:0]  den;
        logic [9:0]  ddst;
        logic [11:0] dtag;
        logic [1:0]  cwe;
        logic [9:0]  cdst;
        logic [11:0] ctag;
        logic [63:0] cdata;
        logic        flush;
        logic        chk;
        logic [63:0] e1data;
        logic [1:0]  e1busy;
        logic [11:0] e1tag;
        logic [63:0] e2data;
        logic [1:0]  e2busy;
        logic [11:0] e2tag;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    arf_rename_multi dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .rs1_i                  (rs1_i),
        .rs2_i                  (rs2_i),
        .rs1_arf_data_o         (rs1_arf_data_o),
        .rs2_arf_data_o         (rs2_arf_data_o),
        .rs1_arf_busy_o         (rs1_arf_busy_o),
        .rs2_arf_busy_o         (rs2_arf_busy_o),
        .rs1_arf_rrftag_o       (rs1_arf_rrftag_o),
        .rs2_arf_rrftag_o       (rs2_arf_rrftag_o),
        .dst_en_setbusy_i       (dst_en_setbusy_i),
        .dst_num_setbusy_i      (dst_num_setbusy_i),
        .dst_rrftag_setbusy_i   (dst_rrftag_setbusy_i),
        .completed_we_i         (completed_we_i),
        .completed_dst_num_i    (completed_dst_num_i),
        .completed_dst_rrftag_i (completed_dst_rrftag_i),
        .from_rrfdata_i         (from_rrfdata_i),
        .flush_i                (flush_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input vec_t s);
        rs1_i                  = s.rs1;
        rs2_i                  = s.rs2;
        dst_en_setbusy_i       = s.den;
        dst_num_setbusy_i      = s.ddst;
        dst_rrftag_setbusy_i   = s.dtag;
        completed_we_i         = s.cwe;
        completed_dst_num_i    = s.cdst;
        completed_dst_rrftag_i = s.ctag;
        from_rrfdata_i         = s.cdata;
        flush_i                = s.flush;
    endtask

    // Data is only meaningful when the operand is not pending.
    task automatic checkOutput(input string nm,
                               input logic [63:0] gotData, input logic [63:0] expData,
                               input logic [1:0] gotBusy, input logic [1:0] expBusy,
                               input logic [11:0] gotTag, input logic [11:0] expTag);
        for (int s = 0; s < 2; s++) begin
            nChecks++;
            if (gotBusy[s] !== expBusy[s]) begin
                nFails++;
                $display("[TB] FAIL %s.s%0d.busy got %0b expected %0b", nm, s, gotBusy[s], expBusy[s]);
            end
            nChecks++;
            if (gotTag[s*6 +: 6] !== expTag[s*6 +: 6]) begin
                nFails++;
                $display("[TB] FAIL %s.s%0d.tag got %0d expected %0d", nm, s, gotTag[s*6 +: 6], expTag[s*6 +: 6]);
            end
            if (!expBusy[s]) begin
                nChecks++;
                if (gotData[s*32 +: 32] !== expData[s*32 +: 32]) begin
                    nFails++;
                    $display("[TB] FAIL %s.s%0d.data got %h expected %h", nm, s, gotData[s*32 +: 32], expData[s*32 +: 32]);
                end
            end
        end
    endtask

    task automatic checkRow(input string nm, input vec_t s);
        checkOutput({nm, ".rs1"}, rs1_arf_data_o, s.e1data, rs1_arf_busy_o, s.e1busy, rs1_arf_rrftag_o, s.e1tag);
        checkOutput({nm, ".rs2"}, rs2_arf_data_o, s.e2data, rs2_arf_busy_o, s.e2busy, rs2_arf_rrftag_o, s.e2tag);
    endtask

    function automatic vec_t idle();
        vec_t z;
        z = '0;
        z.chk = 1'b1;
        return z;
    endfunction

    initial begin
        // v0: reset state on r5
        v = idle(); v.rs1 = {5'd5, 5'd5}; v.rs2 = {5'd5, 5'd5}; tbl.push_back(v);
        // v1: dispatch to r0 must be ignored
        v = idle(); v.den = 2'b01; v.ddst = {5'd0, 5'd0}; v.dtag = {6'd0, 6'd3}; tbl.push_back(v);
        // v2: r0 still clean; slot0 renames r7->10, slot1 sees it forwarded
        v = idle(); v.den = 2'b01; v.ddst = {5'd0, 5'd7}; v.dtag = {6'd0, 6'd10};
        v.rs1 = {5'd7, 5'd7}; v.e1busy = 2'b10; v.e1tag = {6'd10, 6'd0}; tbl.push_back(v);
        // v3: r7 pending with tag 10
        v = idle(); v.rs1 = {5'd7, 5'd7}; v.rs2 = {5'd7, 5'd7};
        v.e1busy = 2'b11; v.e1tag = {6'd10, 6'd10}; v.e2busy = 2'b11; v.e2tag = {6'd10, 6'd10}; tbl.push_back(v);
        // v4: matching commit bypasses data and clears busy
        v = idle(); v.cwe = 2'b01; v.cdst = {5'd0, 5'd7}; v.ctag = {6'd0, 6'd10}; v.cdata = {32'd0, 32'hDEAD};
        v.rs1 = {5'd7, 5'd7}; v.e1data = {32'hDEAD, 32'hDEAD}; v.e1tag = {6'd10, 6'd10}; tbl.push_back(v);
        // v5: committed value visible
        v = idle(); v.rs1 = {5'd7, 5'd7}; v.rs2 = {5'd7, 5'd7};
        v.e1data = {32'hDEAD, 32'hDEAD}; v.e1tag = {6'd10, 6'd10};
        v.e2data = {32'hDEAD, 32'hDEAD}; v.e2tag = {6'd10, 6'd10}; tbl.push_back(v);
        // v6: re-rename r7 to tag 10, forwarded on rs2 of slot1
        v = idle(); v.den = 2'b01; v.ddst = {5'd0, 5'd7}; v.dtag = {6'd0, 6'd10};
        v.rs2 = {5'd7, 5'd7}; v.e2data = {32'd0, 32'hDEAD}; v.e2busy = 2'b10; v.e2tag = {6'd10, 6'd10}; tbl.push_back(v);
        // v7: stale commit (tag 4) leaves r7 pending
        v = idle(); v.cwe = 2'b01; v.cdst = {5'd0, 5'd7}; v.ctag = {6'd0, 6'd4}; v.cdata = {32'd0, 32'h1234};
        v.rs1 = {5'd7, 5'd7}; v.e1busy = 2'b11; v.e1tag = {6'd10, 6'd10}; tbl.push_back(v);
        // v8: commit tag 10 on slot1 while dispatch slot0 renames r7->12
        v = idle(); v.cwe = 2'b10; v.cdst = {5'd7, 5'd0}; v.ctag = {6'd10, 6'd0}; v.cdata = {32'h55, 32'd0};
        v.den = 2'b01; v.ddst = {5'd0, 5'd7}; v.dtag = {6'd0, 6'd12};
        v.rs1 = {5'd7, 5'd7}; v.e1data = {32'd0, 32'h55}; v.e1busy = 2'b10; v.e1tag = {6'd12, 6'd10}; tbl.push_back(v);
        // v9: dispatch wins over commit clear; both slots rename r9, both commits hit r3
        v = idle(); v.den = 2'b11; v.ddst = {5'd9, 5'd9}; v.dtag = {6'd21, 6'd20};
        v.cwe = 2'b11; v.cdst = {5'd3, 5'd3}; v.ctag = {6'd0, 6'd0}; v.cdata = {32'd2, 32'd1};
        v.rs1 = {5'd9, 5'd7}; v.e1busy = 2'b11; v.e1tag = {6'd20, 6'd12};
        v.rs2 = {5'd3, 5'd3}; v.e2data = {32'd2, 32'd2}; tbl.push_back(v);
        // v10: youngest slots won
        v = idle(); v.rs1 = {5'd9, 5'd9}; v.e1busy = 2'b11; v.e1tag = {6'd21, 6'd21};
        v.rs2 = {5'd3, 5'd3}; v.e2data = {32'd2, 32'd2}; tbl.push_back(v);
        // v11: rename r4->30, r6->31
        v = idle(); v.den = 2'b11; v.ddst = {5'd6, 5'd4}; v.dtag = {6'd31, 6'd30};
        v.rs1 = {5'd6, 5'd4}; tbl.push_back(v);
        // v12: both pending
        v = idle(); v.rs1 = {5'd6, 5'd4}; v.e1busy = 2'b11; v.e1tag = {6'd31, 6'd30};
        v.rs2 = {5'd8, 5'd8}; tbl.push_back(v);
        // v13: flush with commit r4=5 and dispatch r8 (reads unchecked)
        v = idle(); v.chk = 1'b0; v.flush = 1'b1;
        v.cwe = 2'b01; v.cdst = {5'd0, 5'd4}; v.ctag = {6'd0, 6'd7}; v.cdata = {32'd0, 32'd5};
        v.den = 2'b01; v.ddst = {5'd0, 5'd8}; v.dtag = {6'd0, 6'd40}; tbl.push_back(v);
        // v14: busy cleared, tags kept, r4 written, r8 untouched
        v = idle(); v.rs1 = {5'd6, 5'd4}; v.e1data = {32'd0, 32'd5}; v.e1tag = {6'd31, 6'd30};
        v.rs2 = {5'd8, 5'd9}; v.e2tag = {6'd0, 6'd21}; tbl.push_back(v);
        // v15: r7 also released by flush
        v = idle(); v.rs1 = {5'd7, 5'd7}; v.e1data = {32'h55, 32'h55}; v.e1tag = {6'd12, 6'd12};
        v.rs2 = {5'd3, 5'd3}; v.e2data = {32'd2, 32'd2}; tbl.push_back(v);
        // v16: commit to r0 neither bypasses nor writes
        v = idle(); v.cwe = 2'b01; v.cdst = {5'd0, 5'd0}; v.cdata = {32'd0, 32'hFF}; tbl.push_back(v);
        // v17: r0 still zero
        v = idle(); tbl.push_back(v);

        applyStimulus(idle());
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            #1;
            if (tbl[i].chk) checkRow($sformatf("v%0d", i), tbl[i]);
            @(negedge clk);
        end

        // Reset mid-stream dominates a same-cycle dispatch and commit.
        v = idle(); v.den = 2'b01; v.ddst = {5'd0, 5'd5}; v.dtag = {6'd0, 6'd9};
        v.cwe = 2'b01; v.cdst = {5'd0, 5'd5}; v.cdata = {32'd0, 32'h77};
        applyStimulus(v);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        v = idle(); v.rs1 = {5'd7, 5'd5}; v.rs2 = {5'd9, 5'd4};
        applyStimulus(v);
        #1;
        checkRow("midreset", v);
        @(negedge clk);

        // After reset the table works again: rename r5->9 and read it next cycle.
        v = idle(); v.den = 2'b01; v.ddst = {5'd0, 5'd5}; v.dtag = {6'd0, 6'd9};
        applyStimulus(v);
        @(negedge clk);
        v = idle(); v.rs1 = {5'd5, 5'd5}; v.e1busy = 2'b11; v.e1tag = {6'd9, 6'd9};
        applyStimulus(v);
        #1;
        checkRow("postreset", v);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
